multicycle_ctrl: RTL

Main control FSM of the multicycle MIPS core. It sits directly upstream of the immediate extender and drives that block's 2-bit extension-mode select. It also drives every other datapath strobe and mux select for the five-phase IF/ID/EXE/MEM/WB sequence. It keeps a retired-instruction counter for debug and performance checks.

---
 rtl/mips_defs.sv | 84 ++++++++
 rtl/ctrl_decode.sv | 100 ++++++++++
 rtl/multicycle_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path:
// opcodes, functs, ALU/extender codes, FSM states and the strobe bundle.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EXE  = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_IDLE = 3'd5;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       illegal;
    } ctrl_t;

    // Quiescent bundle: nothing written, extender left in sign mode.
    localparam ctrl_t CTRL_IDLE = '{
        ext_op: EXT_SIGN,
        default: '0
    };

    // Extender mode an opcode needs for its immediate.
    function automatic logic [1:0] ext_for(input logic [5:0] op);
        case (op)
            OP_ORI:  return EXT_ZERO;
            OP_LUI:  return EXT_LUI;
            default: return EXT_SIGN;
        endcase
    endfunction

    // Opcodes that may proceed past ID into EXE.
    function automatic logic is_exe_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_ADDIU, OP_ORI,
            OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (state, opcode, funct) to the datapath
// strobe bundle, the next FSM state and the retire flag.
module ctrl_decode
    import mips_defs::*;
(
    input  logic [2:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic [2:0] next_o,
    output logic       retire_o
);

    // Per-state strobe decode; each state sets only what it needs.
    always_comb begin
        ctrl_o   = CTRL_IDLE;
        next_o   = ST_IF;
        retire_o = 1'b0;
        case (state_i)
            ST_IDLE: next_o = ST_IF;
            ST_IF: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                next_o           = ST_ID;
            end
            ST_ID: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                if (opcode_i == OP_J) begin
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = PCSRC_JUMP;
                    retire_o        = 1'b1;
                end else if (is_exe_op(opcode_i)) begin
                    next_o = ST_EXE;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            ST_EXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.ext_op    = ext_for(opcode_i);
                next_o           = ST_WB;
                case (opcode_i)
                    OP_RTYPE: begin
                        case (funct_i)
                            FN_ADDU: ctrl_o.alu_op = ALU_ADD;
                            FN_SUBU: ctrl_o.alu_op = ALU_SUB;
                            FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                            default: begin
                                ctrl_o.illegal = 1'b1;
                                next_o         = ST_IF;
                            end
                        endcase
                    end
                    OP_ORI: begin
                        ctrl_o.alu_src_b = SRCB_IMM;
                        ctrl_o.alu_op    = ALU_OR;
                    end
                    OP_ADDIU: ctrl_o.alu_src_b = SRCB_IMM;
                    OP_LW, OP_SW: begin
                        ctrl_o.alu_src_b = SRCB_IMM;
                        next_o           = ST_MEM;
                    end
                    OP_LUI: begin
                        ctrl_o.alu_src_b = SRCB_IMM;
                        ctrl_o.alu_op    = ALU_PASS;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_op        = ALU_SUB;
                        ctrl_o.pc_write_cond = 1'b1;
                        ctrl_o.pc_src        = PCSRC_ALUOUT;
                        retire_o             = 1'b1;
                        next_o               = ST_IF;
                    end
                    default: next_o = ST_IF;
                endcase
            end
            ST_MEM: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.ext_op    = ext_for(opcode_i);
                if (opcode_i == OP_SW) begin
                    ctrl_o.mem_write = 1'b1;
                    retire_o         = 1'b1;
                end else if (opcode_i == OP_LW) begin
                    next_o = ST_WB;
                end
            end
            ST_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = (opcode_i == OP_RTYPE);
                ctrl_o.mem_to_reg = (opcode_i == OP_LW);
                ctrl_o.ext_op     = ext_for(opcode_i);
                retire_o          = 1'b1;
            end
            default: next_o = ST_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control: state register, post-reset hold
// and retired-instruction counter around the strobe decoder.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W         = 32,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PC_write,
    output logic             PC_write_cond,
    output logic [1:0]       PC_src,
    output logic             IR_write,
    output logic             Mem_write,
    output logic             Reg_write,
    output logic             Reg_dst,
    output logic             Mem_to_reg,
    output logic             ALU_srcA,
    output logic [1:0]       ALU_srcB,
    output logic [2:0]       ALU_op,
    output logic [1:0]       Ext_op,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic HOLD_INIT = (RESET_PC_HOLD != 0);

    logic [2:0]       state_q, state_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       nxt;
    logic             retire;
    ctrl_t            ctrl;

    // The branch condition is applied in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    ctrl_decode u_dec (
        .state_i  (state_q),
        .opcode_i (opcode),
        .funct_i  (funct),
        .ctrl_o   (ctrl),
        .next_o   (nxt),
        .retire_o (retire)
    );

    // Next state: IDLE lingers while the hold bit is still set.
    always_comb begin
        state_d = nxt;
        hold_d  = hold_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, retire};
        if (state_q == ST_IDLE) begin
            hold_d = 1'b0;
            if (hold_q) state_d = ST_IDLE;
        end
    end

    // State, hold and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= HOLD_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC_write      = ctrl.pc_write;
    assign PC_write_cond = ctrl.pc_write_cond;
    assign PC_src        = ctrl.pc_src;
    assign IR_write      = ctrl.ir_write;
    assign Mem_write     = ctrl.mem_write;
    assign Reg_write     = ctrl.reg_write;
    assign Reg_dst       = ctrl.reg_dst;
    assign Mem_to_reg    = ctrl.mem_to_reg;
    assign ALU_srcA      = ctrl.alu_src_a;
    assign ALU_srcB      = ctrl.alu_src_b;
    assign ALU_op        = ctrl.alu_op;
    assign Ext_op        = ctrl.ext_op;
    assign illegal       = ctrl.illegal;
    assign state         = state_q;
    assign instr_cnt     = cnt_q;

endmodule
